// File: rtl/sound_reg_sequencer.sv
// Script player: replays (addr, data, delay) table entries as single-cycle IO-register bus writes.
// Optional readback-and-compare of each write is enabled by defining SOUND_SEQ_READBACK_EN.
module sound_reg_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned DELAY_W = 24
) (
    input  logic                  I_CLK,
    input  logic                  I_RESET_L,
    input  logic                  I_PROG_WE,
    input  logic [AW-1:0]         I_PROG_ADDR,
    input  logic [24+DELAY_W-1:0] I_PROG_DATA,
    input  logic [AW:0]           I_LEN,
    input  logic                  I_START,
    input  logic                  I_STOP,
    input  logic                  I_LOOP,
    output logic [15:0]           O_IOREG_ADDR,
    output logic [7:0]            O_IOREG_DATA,
    output logic                  O_IOREG_EN,
    output logic                  O_IOREG_WE_L,
    output logic                  O_NEW_SOUND,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic [7:0]            O_PASS_COUNT
`ifdef SOUND_SEQ_READBACK_EN
   ,input  logic [7:0]            I_IOREG_RDATA,
    output logic                  O_IOREG_RE_L,
    output logic                  O_MISMATCH
`endif
);

    localparam int unsigned EW = 24 + DELAY_W;
    localparam logic [AW:0]        LenOne = 1;
    localparam logic [AW:0]        LenMax = DEPTH[AW:0];
    localparam logic [AW-1:0]      IdxOne = 1;
    localparam logic [DELAY_W-1:0] DlyOne = 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StWrite, StHold, StWait, StNext, StRdbk, StRchk
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW:0]        len_q, len_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [7:0]         pass_q, pass_d;
    logic               done_q, done_d;
    logic               stop_q, stop_d;
    logic               mism_q, mism_d;
    logic [EW-1:0]      rd_q;
    logic [EW-1:0]      mem [DEPTH];

    logic [DELAY_W-1:0] dly;
    logic               last;
    logic               start_ok;
    logic               done_now;

    assign dly      = rd_q[EW-1:24];
    assign last     = ({1'b0, idx_q} == (len_q - LenOne));
    assign start_ok = I_START && !I_STOP;

    // Table is not reset; writes are only honoured while idle.
    always_ff @(posedge I_CLK) begin
        if (I_PROG_WE && (state_q == StIdle)) begin
            mem[I_PROG_ADDR] <= I_PROG_DATA;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= '0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
            mism_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
            mism_q  <= mism_d;
            if (state_q == StFetch) begin
                rd_q <= mem[idx_q];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        done_d   = 1'b0;
        stop_d   = stop_q;
        mism_d   = mism_q;
        done_now = 1'b0;
        unique case (state_q)
            StIdle: begin
                stop_d = 1'b0;
                if (start_ok) begin
                    pass_d = '0;
                    mism_d = 1'b0;
                    if (I_LEN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StFetch;
                        idx_d   = '0;
                        len_d   = (I_LEN > LenMax) ? LenMax : I_LEN;
                    end
                end
            end
            StFetch: state_d = I_STOP ? StIdle : StWrite;
            StWrite: begin
                // A stop here is deferred so the bus write finishes its hold cycle.
                stop_d  = I_STOP;
                state_d = StHold;
            end
            StHold: begin
                cnt_d = dly - DlyOne;
                if (stop_q || I_STOP) begin
                    state_d = StIdle;
                end else begin
`ifdef SOUND_SEQ_READBACK_EN
                    state_d = StRdbk;
`else
                    state_d = (dly == '0) ? StNext : StWait;
`endif
                end
            end
`ifdef SOUND_SEQ_READBACK_EN
            StRdbk: state_d = I_STOP ? StIdle : StRchk;
            StRchk: begin
                if (I_IOREG_RDATA != rd_q[7:0]) begin
                    mism_d = 1'b1;
                end
                if (I_STOP) begin
                    state_d = StIdle;
                end else begin
                    state_d = (dly == '0) ? StNext : StWait;
                end
            end
`endif
            StWait: begin
                if (I_STOP) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q - DlyOne;
                end
            end
            StNext: begin
                if (I_STOP) begin
                    state_d = StIdle;
                end else if (!last) begin
                    idx_d   = idx_q + IdxOne;
                    state_d = StFetch;
                end else begin
                    pass_d = pass_q + 8'd1;
                    if (I_LOOP) begin
                        idx_d   = '0;
                        state_d = StFetch;
                    end else begin
                        state_d  = StIdle;
                        done_now = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign O_IOREG_ADDR = rd_q[23:8];
    assign O_IOREG_DATA = rd_q[7:0];
    assign O_IOREG_EN   = (state_q == StWrite) || (state_q == StHold);
    assign O_IOREG_WE_L = (state_q != StWrite);
    assign O_NEW_SOUND  = (state_q == StWrite) && (idx_q == '0);
    assign O_BUSY       = (state_q != StIdle);
    assign O_DONE       = done_q || done_now;
    assign O_PASS_COUNT = pass_q;
`ifdef SOUND_SEQ_READBACK_EN
    assign O_IOREG_RE_L = (state_q != StRdbk);
    assign O_MISMATCH   = mism_q;
`endif

endmodule
